// File: rtl/adma_dm_axi_r.sv
// Read-side AXI data mover: R channel -> channel data buffer, with a local burst-boundary counter.
// Optional RLAST/RRESP checking and sticky error flags are enabled by defining ADMA_DM_R_CHK_EN.
module adma_dm_axi_r #(
  parameter int unsigned ATX_LEN_W      = 8,
  parameter int unsigned ATX_SRC_DATA_W = 256,
  parameter int unsigned ATX_NUM_OSTD   = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [ATX_LEN_W-1:0]      atx_arlen,
  input  logic                      atx_vld,
  output logic                      atx_rdy,
  output logic [ATX_SRC_DATA_W-1:0] atx_rdata,
  output logic                      atx_rlast,
  output logic                      atx_rdata_vld,
  input  logic                      atx_rdata_rdy,
  input  logic [ATX_SRC_DATA_W-1:0] m_rdata_i,
  input  logic [1:0]                m_rresp_i,
  input  logic                      m_rlast_i,
  input  logic                      m_rvalid_i,
  output logic                      m_rready_o,
  output logic                      err_resp_o,
  output logic                      err_last_o,
  input  logic                      err_clr_i
);

  localparam int unsigned PTR_W = $clog2(ATX_NUM_OSTD);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ATX_LEN_W-1:0]      len_mem [ATX_NUM_OSTD];
  logic [PTR_W-1:0]          len_wptr;
  logic [PTR_W-1:0]          len_rptr;
  logic [CNT_W-1:0]          len_cnt;
  logic [ATX_LEN_W-1:0]      len_h;
  logic                      fifo_nonempty;
  logic                      len_push;
  logic                      len_pop;

  logic [ATX_LEN_W-1:0]      cnt;
  logic                      exp_last;
  logic                      r_hsk;

  logic [ATX_SRC_DATA_W-1:0] sb_data [2];
  logic [1:0]                sb_last;
  logic                      sb_wptr;
  logic                      sb_rptr;
  logic [1:0]                sb_cnt;
  logic                      sb_space;
  logic                      sb_pop;

  // Ready/valid terms derive only from registered occupancy, keeping RREADY off the buffer-ready path
  assign fifo_nonempty = (len_cnt != '0);
  assign atx_rdy       = (len_cnt != CNT_W'(ATX_NUM_OSTD));
  assign len_h         = len_mem[len_rptr];
  assign exp_last      = (cnt == len_h);
  assign sb_space      = (sb_cnt != 2'd2);
  assign m_rready_o    = sb_space & fifo_nonempty;
  assign r_hsk         = m_rvalid_i & m_rready_o;
  assign len_push      = atx_vld & atx_rdy;
  assign len_pop       = r_hsk & exp_last;
  assign atx_rdata_vld = (sb_cnt != 2'd0);
  assign sb_pop        = atx_rdata_vld & atx_rdata_rdy;
  assign atx_rdata     = sb_data[sb_rptr];
  assign atx_rlast     = sb_last[sb_rptr];

  // Outstanding burst-length FIFO
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_wptr <= '0;
      len_rptr <= '0;
      len_cnt  <= '0;
      for (int i = 0; i < int'(ATX_NUM_OSTD); i++) len_mem[i] <= '0;
    end else begin
      if (len_push) begin
        len_mem[len_wptr] <= atx_arlen;
        len_wptr          <= len_wptr + PTR_W'(1);
      end
      if (len_pop) len_rptr <= len_rptr + PTR_W'(1);
      case ({len_push, len_pop})
        2'b10:   len_cnt <= len_cnt + CNT_W'(1);
        2'b01:   len_cnt <= len_cnt - CNT_W'(1);
        default: len_cnt <= len_cnt;
      endcase
    end
  end

  // Beat counter regenerates the burst boundary from the head length
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (r_hsk) begin
      cnt <= exp_last ? '0 : cnt + ATX_LEN_W'(1);
    end
  end

  // Two-entry skid buffer toward the data buffer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sb_data[0] <= '0;
      sb_data[1] <= '0;
      sb_last    <= '0;
      sb_wptr    <= 1'b0;
      sb_rptr    <= 1'b0;
      sb_cnt     <= 2'd0;
    end else begin
      if (r_hsk) begin
        sb_data[sb_wptr] <= m_rdata_i;
        sb_last[sb_wptr] <= exp_last;
        sb_wptr          <= ~sb_wptr;
      end
      if (sb_pop) sb_rptr <= ~sb_rptr;
      case ({r_hsk, sb_pop})
        2'b10:   sb_cnt <= sb_cnt + 2'd1;
        2'b01:   sb_cnt <= sb_cnt - 2'd1;
        default: sb_cnt <= sb_cnt;
      endcase
    end
  end

`ifdef ADMA_DM_R_CHK_EN
  logic err_resp_q;
  logic err_last_q;
  logic unused_resp0;

  assign unused_resp0 = m_rresp_i[0];

  // Sticky error flags; a new error in the clear cycle keeps its flag set
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_resp_q <= 1'b0;
      err_last_q <= 1'b0;
    end else begin
      if (r_hsk && m_rresp_i[1])           err_resp_q <= 1'b1;
      else if (err_clr_i)                  err_resp_q <= 1'b0;
      if (r_hsk && (m_rlast_i != exp_last)) err_last_q <= 1'b1;
      else if (err_clr_i)                  err_last_q <= 1'b0;
    end
  end

  assign err_resp_o = err_resp_q;
  assign err_last_o = err_last_q;
`else
  logic unused_chk;

  assign unused_chk = ^{m_rresp_i, m_rlast_i, err_clr_i};
  assign err_resp_o = 1'b0;
  assign err_last_o = 1'b0;
`endif

endmodule

// File: tb/tb_adma_dm_axi_r.sv
// Randomized bench for adma_dm_axi_r against a queue-based model of bursts, beats and error flags.
module tb_adma_dm_axi_r;

  localparam int NOSTD = 4;
`ifdef ADMA_DM_R_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   atx_arlen;
  logic         atx_vld;
  logic         atx_rdy;
  logic [255:0] atx_rdata;
  logic         atx_rlast;
  logic         atx_rdata_vld;
  logic         atx_rdata_rdy;
  logic [255:0] m_rdata_i;
  logic [1:0]   m_rresp_i;
  logic         m_rlast_i;
  logic         m_rvalid_i;
  logic         m_rready_o;
  logic         err_resp_o;
  logic         err_last_o;
  logic         err_clr_i;

  always #5 clk = ~clk;

  adma_dm_axi_r dut (
    .clk(clk), .rst_n(rst_n),
    .atx_arlen(atx_arlen), .atx_vld(atx_vld), .atx_rdy(atx_rdy),
    .atx_rdata(atx_rdata), .atx_rlast(atx_rlast),
    .atx_rdata_vld(atx_rdata_vld), .atx_rdata_rdy(atx_rdata_rdy),
    .m_rdata_i(m_rdata_i), .m_rresp_i(m_rresp_i), .m_rlast_i(m_rlast_i),
    .m_rvalid_i(m_rvalid_i), .m_rready_o(m_rready_o),
    .err_resp_o(err_resp_o), .err_last_o(err_last_o), .err_clr_i(err_clr_i)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: pending burst lengths, beats held for the buffer, flags
  int           len_q[$];
  int           beat_idx;
  logic [255:0] dq[$];
  logic         lq[$];
  logic         out_log[$];
  logic         m_err_last;
  logic         m_err_resp;
  int           cyc, hsk_cnt, first_hsk, last_hsk, first_pop, push_cnt, last_push_cyc;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Entered just after a falling edge with inputs set; returns at the next falling edge
  task automatic step();
    logic el;
    logic set_l;
    logic set_r;
    #1;
    if (!rst_n) begin
      @(posedge clk);
      len_q.delete(); dq.delete(); lq.delete();
      beat_idx = 0; m_err_last = 1'b0; m_err_resp = 1'b0;
    end else begin
      check("atx_rdy", 256'(atx_rdy), 256'(len_q.size() < NOSTD));
      check("m_rready", 256'(m_rready_o), 256'((dq.size() < 2) && (len_q.size() > 0)));
      check("rdata_vld", 256'(atx_rdata_vld), 256'(dq.size() > 0));
      check("err_last", 256'(err_last_o), 256'(m_err_last));
      check("err_resp", 256'(err_resp_o), 256'(m_err_resp));
      set_l = 1'b0;
      set_r = 1'b0;
      if (atx_rdata_vld && atx_rdata_rdy) begin
        if (dq.size() == 0) check("spurious_beat", 256'(1), 256'(0));
        else begin
          check("rdata", atx_rdata, dq.pop_front());
          check("rlast", 256'(atx_rlast), 256'(lq.pop_front()));
          out_log.push_back(atx_rlast);
        end
      end
      if (m_rvalid_i && m_rready_o && len_q.size() > 0) begin
        el = (beat_idx == len_q[0]);
        dq.push_back(m_rdata_i);
        lq.push_back(el);
        set_l = (m_rlast_i != el);
        set_r = m_rresp_i[1];
        hsk_cnt++;
        if (first_hsk < 0) first_hsk = cyc;
        last_hsk = cyc;
        if (el) begin
          void'(len_q.pop_front());
          beat_idx = 0;
          if (first_pop < 0) first_pop = cyc;
        end else beat_idx++;
      end
      if (atx_vld && atx_rdy) begin
        len_q.push_back(int'(atx_arlen));
        push_cnt++;
        last_push_cyc = cyc;
      end
      if (CHK) begin
        m_err_last = set_l | (m_err_last & ~err_clr_i);
        m_err_resp = set_r | (m_err_resp & ~err_clr_i);
      end
      @(posedge clk);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic drive(input bit push, input int len, input int vld_pct, input int rdy_pct,
                       input int err_pct, input bit clr);
    atx_vld   = push;
    atx_arlen = 8'(len);
    m_rvalid_i = ($urandom_range(0, 99) < vld_pct);
    for (int i = 0; i < 8; i++) m_rdata_i[i*32 +: 32] = $urandom();
    m_rlast_i = (len_q.size() > 0) ? (beat_idx == len_q[0]) : 1'b0;
    m_rresp_i = 2'b00;
    if ($urandom_range(0, 99) < err_pct) m_rlast_i = ~m_rlast_i;
    if ($urandom_range(0, 99) < err_pct) m_rresp_i = 2'($urandom_range(0, 3));
    atx_rdata_rdy = ($urandom_range(0, 99) < rdy_pct);
    err_clr_i = clr;
    step();
    atx_vld = 1'b0;
    err_clr_i = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while ((len_q.size() > 0 || dq.size() > 0) && g < 3000) begin
      drive(0, 0, 100, 100, 0, 0);
      g++;
    end
    check("drain_done", 256'(len_q.size() + dq.size()), 256'(0));
  endtask

  task automatic reset_stats();
    hsk_cnt = 0; first_hsk = -1; last_hsk = -1; first_pop = -1; push_cnt = 0;
    last_push_cyc = -1;
    out_log.delete();
  endtask

  task automatic burst_stream(input int len, input int rdy_pct, input string tag);
    int g = 0;
    int nl = 0;
    reset_stats();
    drive(1, len, 0, 100, 0, 0);
    while (hsk_cnt < len + 1 && g < 2000) begin
      drive(0, 0, 100, rdy_pct, 0, 0);
      g++;
    end
    drain();
    check({tag, "_beats"}, 256'(out_log.size()), 256'(len + 1));
    foreach (out_log[i]) if (out_log[i]) nl++;
    check({tag, "_nlast"}, 256'(nl), 256'(1));
    if (out_log.size() == len + 1) check({tag, "_last_pos"}, 256'(out_log[len]), 256'(1));
  endtask

  initial begin
    int g;
    int nl;
    rst_n = 1'b0; atx_vld = 1'b0; atx_arlen = '0; atx_rdata_rdy = 1'b0;
    m_rdata_i = '0; m_rresp_i = '0; m_rlast_i = 1'b0; m_rvalid_i = 1'b0; err_clr_i = 1'b0;
    beat_idx = 0; m_err_last = 1'b0; m_err_resp = 1'b0; cyc = 0;
    reset_stats();
    @(negedge clk);
    step();
    step();
    rst_n = 1'b1;
    check("rst_rdy", 256'(atx_rdy), 256'(1));
    check("rst_vld", 256'(atx_rdata_vld), 256'(0));
    check("rst_rlast", 256'(atx_rlast), 256'(0));
    check("rst_rdata", atx_rdata, 256'(0));
    check("rst_rready", 256'(m_rready_o), 256'(0));
    check("rst_errs", 256'({err_last_o, err_resp_o}), 256'(0));

    // Single-beat burst
    reset_stats();
    drive(1, 0, 0, 0, 0, 0);
    check("sb_rready_next", 256'(m_rready_o), 256'(1));
    m_rvalid_i = 1'b1; m_rdata_i = 256'hA5; m_rlast_i = 1'b1; m_rresp_i = 2'b00;
    atx_rdata_rdy = 1'b0;
    step();
    m_rvalid_i = 1'b0;
    check("sb_vld", 256'(atx_rdata_vld), 256'(1));
    check("sb_data", atx_rdata, 256'hA5);
    check("sb_rlast", 256'(atx_rlast), 256'(1));
    check("sb_rready_after", 256'(m_rready_o), 256'(0));
    atx_rdata_rdy = 1'b1;
    step();
    check("sb_vld_after", 256'(atx_rdata_vld), 256'(0));

    // Back-to-back bursts 3,1,0,7 at full rate
    reset_stats();
    drive(1, 3, 0, 100, 0, 0);
    drive(1, 1, 0, 100, 0, 0);
    drive(1, 0, 0, 100, 0, 0);
    drive(1, 7, 0, 100, 0, 0);
    g = 0;
    while (hsk_cnt < 15 && g < 40) begin drive(0, 0, 100, 100, 0, 0); g++; end
    drain();
    check("b2b_hsk", 256'(hsk_cnt), 256'(15));
    check("b2b_span", 256'(last_hsk - first_hsk), 256'(14));
    check("b2b_beats", 256'(out_log.size()), 256'(15));
    if (out_log.size() == 15) begin
      nl = 0;
      foreach (out_log[i]) if (out_log[i]) nl++;
      check("b2b_nlast", 256'(nl), 256'(4));
      check("b2b_last4", 256'(out_log[3]), 256'(1));
      check("b2b_last6", 256'(out_log[5]), 256'(1));
      check("b2b_last7", 256'(out_log[6]), 256'(1));
      check("b2b_last15", 256'(out_log[14]), 256'(1));
    end

    // Backpressure on a 16-beat burst, and a maximum-length burst
    burst_stream(15, 50, "bp");
    burst_stream(255, 100, "maxlen");
    check("maxlen_span", 256'(last_hsk - first_hsk), 256'(255));

    // Outstanding limit: fifth length waits for the first burst to retire
    reset_stats();
    for (int i = 0; i < 4; i++) drive(1, 1, 0, 100, 0, 0);
    check("ostd_full", 256'(atx_rdy), 256'(0));
    g = 0;
    while (push_cnt < 5 && g < 20) begin drive(1, 1, 100, 100, 0, 0); g++; end
    check("ostd_push5", 256'(push_cnt), 256'(5));
    check("ostd_timing", 256'(last_push_cyc), 256'(first_pop + 1));
    drain();

    // Error flags: early RLAST on beat 2, SLVERR on beat 3
    reset_stats();
    drive(1, 3, 0, 100, 0, 0);
    for (int b = 0; b < 4; b++) begin
      m_rvalid_i = 1'b1; m_rdata_i = 256'(b + 16'h100);
      m_rlast_i = (b == 1) || (b == 3);
      m_rresp_i = (b == 2) ? 2'b10 : 2'b00;
      atx_rdata_rdy = 1'b1;
      step();
    end
    m_rvalid_i = 1'b0;
    drain();
    check("err_last_set", 256'(err_last_o), 256'(CHK));
    check("err_resp_set", 256'(err_resp_o), 256'(CHK));
    if (out_log.size() == 4) begin
      check("err_beat2_rlast", 256'(out_log[1]), 256'(0));
      check("err_beat4_rlast", 256'(out_log[3]), 256'(1));
    end
    drive(0, 0, 0, 100, 0, 1);
    check("err_clr", 256'({err_last_o, err_resp_o}), 256'(0));
    drive(1, 0, 0, 100, 0, 0);
    m_rvalid_i = 1'b1; m_rlast_i = 1'b1; m_rresp_i = 2'b11; err_clr_i = 1'b1;
    step();
    m_rvalid_i = 1'b0; err_clr_i = 1'b0; m_rresp_i = 2'b00;
    check("err_set_wins", 256'(err_resp_o), 256'(CHK));
    drive(0, 0, 0, 100, 0, 1);
    drain();

    // Mid-burst reset
    reset_stats();
    drive(1, 7, 0, 0, 0, 0);
    drive(0, 0, 100, 0, 0, 0);
    drive(0, 0, 100, 0, 0, 0);
    m_rvalid_i = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mrst_rdy", 256'(atx_rdy), 256'(1));
    check("mrst_vld", 256'(atx_rdata_vld), 256'(0));
    check("mrst_rlast", 256'(atx_rlast), 256'(0));
    check("mrst_rdata", atx_rdata, 256'(0));
    check("mrst_rready", 256'(m_rready_o), 256'(0));
    check("mrst_errs", 256'({err_last_o, err_resp_o}), 256'(0));
    reset_stats();
    drive(1, 1, 0, 100, 0, 0);
    drain();
    check("mrst_beats", 256'(out_log.size()), 256'(2));
    if (out_log.size() == 2) check("mrst_lasts", 256'({out_log[0], out_log[1]}), 256'(2'b01));

    // Random traffic with sporadic errors and clears
    for (int i = 0; i < 600; i++)
      drive(bit'($urandom_range(0, 1)), int'($urandom_range(0, 7)), 70, 60, 5,
            ($urandom_range(0, 99) < 5));
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
